// File: rtl/conv_img_reader.sv
// Output-side reader for the convolution datapath: snapshots the flat image bus on load and
// streams it row-major, one pixel per valid/ready transfer, tagged with row/col/last.
module conv_img_reader #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ROWS   = 9,
  parameter int unsigned COLS   = 9
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          load,
  input  logic [ROWS*COLS*DATA_W-1:0]   conv_img,
  output logic                          busy,
  output logic [DATA_W-1:0]             pix_data,
  output logic                          pix_valid,
  input  logic                          pix_ready,
  output logic [$clog2(ROWS)-1:0]       pix_row,
  output logic [$clog2(COLS)-1:0]       pix_col,
  output logic                          pix_last,
  output logic                          done
);

  localparam int unsigned RowW = $clog2(ROWS);
  localparam int unsigned ColW = $clog2(COLS);
  localparam logic [RowW-1:0] LastRow = RowW'(ROWS - 1);
  localparam logic [ColW-1:0] LastCol = ColW'(COLS - 1);

  typedef enum logic [1:0] {StIdle, StStream, StDone} state_e;

  state_e                        state_q, state_d;
  logic [ROWS*COLS*DATA_W-1:0]   snap_q, snap_d;
  logic [RowW-1:0]               row_q, row_d;
  logic [ColW-1:0]               col_q, col_d;
  int unsigned                   idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      snap_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    snap_d    = snap_q;
    row_d     = row_q;
    col_d     = col_q;
    pix_valid = (state_q == StStream);
    done      = (state_q == StDone);
    busy      = (state_q != StIdle);
    idx       = 32'(row_q) * COLS + 32'(col_q);
    // Data is forced to zero outside the stream so idle outputs match reset values.
    pix_data  = pix_valid ? snap_q[idx*DATA_W +: DATA_W] : '0;
    pix_row   = row_q;
    pix_col   = col_q;
    pix_last  = pix_valid && (row_q == LastRow) && (col_q == LastCol);

    unique case (state_q)
      StIdle: begin
        if (load) begin
          snap_d  = conv_img;
          row_d   = '0;
          col_d   = '0;
          state_d = StStream;
        end
      end
      StStream: begin
        if (pix_ready) begin
          if (col_q == LastCol) begin
            col_d = '0;
            if (row_q == LastRow) begin
              row_d   = '0;
              state_d = StDone;
            end else begin
              row_d = row_q + 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_conv_img_reader.sv
// Directed bench for conv_img_reader: basic stream, backpressure, snapshot isolation,
// load-while-busy, mid-stream reset, reset/load collision and full-range data.
module tb_conv_img_reader;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ROWS   = 9;
  localparam int unsigned COLS   = 9;
  localparam int unsigned NPIX   = ROWS * COLS;

  logic                        clk;
  logic                        rst;
  logic                        load;
  logic [NPIX*DATA_W-1:0]      conv_img;
  logic                        busy;
  logic [DATA_W-1:0]           pix_data;
  logic                        pix_valid;
  logic                        pix_ready;
  logic [$clog2(ROWS)-1:0]     pix_row;
  logic [$clog2(COLS)-1:0]     pix_col;
  logic                        pix_last;
  logic                        done;

  int ntests;
  int nfail;
  int got;

  conv_img_reader #(
    .DATA_W (DATA_W),
    .ROWS   (ROWS),
    .COLS   (COLS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .conv_img  (conv_img),
    .busy      (busy),
    .pix_data  (pix_data),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_row   (pix_row),
    .pix_col   (pix_col),
    .pix_last  (pix_last),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // mode 0: k+1, 1: all FF, 2: 255-k, 3: scrambled pattern
  function automatic logic [7:0] exp_pix(input int mode, input int k);
    case (mode)
      0:       return 8'(k + 1);
      1:       return 8'hFF;
      2:       return 8'(255 - k);
      default: return 8'((k * 7 + 3) & 255);
    endcase
  endfunction

  task automatic fill(input int mode);
    for (int k = 0; k < int'(NPIX); k++) conv_img[k*DATA_W +: DATA_W] = exp_pix(mode, k);
  endtask

  task automatic do_load();
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  // Streams pixels start_k..stop_k-1; bp selects ready pattern 1,0,0,1.
  task automatic stream(input int mode, input bit bp, input int start_k, input int stop_k,
                        output int nxt);
    int k;
    int c;
    k = start_k;
    c = 0;
    while (k < stop_k && c < 1000) begin
      pix_ready = bp ? ((c % 4) == 0 || (c % 4) == 3) : 1'b1;
      check("valid", 32'(pix_valid), 32'd1);
      check("data", 32'(pix_data), 32'(exp_pix(mode, k)));
      check("row", 32'(pix_row), 32'(k / COLS));
      check("col", 32'(pix_col), 32'(k % COLS));
      check("last", 32'(pix_last), 32'(k == int'(NPIX) - 1));
      check("busy", 32'(busy), 32'd1);
      check("done_early", 32'(done), 32'd0);
      if (pix_valid && pix_ready) k++;
      tick();
      c++;
    end
    check("stream_budget", 32'(c < 1000), 32'd1);
    nxt = k;
  endtask

  task automatic finish_check();
    check("done_pulse", 32'(done), 32'd1);
    check("done_valid", 32'(pix_valid), 32'd0);
    check("done_busy", 32'(busy), 32'd1);
    check("done_last", 32'(pix_last), 32'd0);
    tick();
    check("post_done", 32'(done), 32'd0);
    check("post_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    ntests    = 0;
    nfail     = 0;
    rst       = 1'b1;
    load      = 1'b0;
    pix_ready = 1'b0;
    conv_img  = '0;
    repeat (5) tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(pix_valid), 32'd0);
    check("rst_data", 32'(pix_data), 32'd0);
    check("rst_row", 32'(pix_row), 32'd0);
    check("rst_col", 32'(pix_col), 32'd0);
    check("rst_last", 32'(pix_last), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    tick();
    check("idle_valid", 32'(pix_valid), 32'd0);

    // Basic stream; load during the done cycle must be ignored.
    fill(0);
    pix_ready = 1'b1;
    do_load();
    stream(0, 1'b0, 0, NPIX, got);
    check("basic_count", 32'(got), 32'(NPIX));
    check("done_pulse", 32'(done), 32'd1);
    check("done_valid", 32'(pix_valid), 32'd0);
    load = 1'b1;
    tick();
    load = 1'b0;
    check("load_in_done_busy", 32'(busy), 32'd0);
    check("load_in_done_valid", 32'(pix_valid), 32'd0);
    tick();
    check("load_in_done_idle", 32'(busy), 32'd0);

    // Backpressure.
    do_load();
    stream(0, 1'b1, 0, NPIX, got);
    finish_check();

    // Snapshot isolation, then reload picks up the new image.
    fill(0);
    do_load();
    fill(1);
    stream(0, 1'b0, 0, NPIX, got);
    finish_check();
    do_load();
    stream(1, 1'b0, 0, NPIX, got);
    finish_check();

    // Load ignored while busy.
    fill(0);
    do_load();
    stream(0, 1'b0, 0, 40, got);
    pix_ready = 1'b0;
    fill(3);
    do_load();
    check("busy_load_data", 32'(pix_data), 32'd41);
    check("busy_load_col", 32'(pix_col), 32'd4);
    check("busy_load_row", 32'(pix_row), 32'd4);
    stream(0, 1'b0, 40, NPIX, got);
    finish_check();

    // Reset mid-stream.
    fill(0);
    do_load();
    stream(0, 1'b0, 0, 20, got);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_valid", 32'(pix_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_row", 32'(pix_row), 32'd0);
    check("mid_rst_col", 32'(pix_col), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    tick();
    check("mid_rst_done2", 32'(done), 32'd0);
    do_load();
    stream(0, 1'b0, 0, NPIX, got);
    finish_check();

    // Simultaneous reset and load: reset wins.
    rst  = 1'b1;
    load = 1'b1;
    tick();
    rst  = 1'b0;
    load = 1'b0;
    check("rst_load_busy", 32'(busy), 32'd0);
    check("rst_load_valid", 32'(pix_valid), 32'd0);
    tick();
    check("rst_load_idle", 32'(busy), 32'd0);

    // Full-range data.
    fill(2);
    do_load();
    stream(2, 1'b1, 0, NPIX, got);
    finish_check();

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/conv_img_reader.md
# conv_img_reader

Output-side reader for the convolution datapath. Snapshots the flat 9x9 convolved image bus `conv_img` produced by the padding/convolution block and streams it out one 8-bit pixel per transfer, row-major, over a valid/ready handshake. Row/column tags and a last flag go to downstream consumers such as a display/UART bridge or a result buffer. It is the consumer-side counterpart of the padded-matrix writer feeding the convolution.

## Interface
Parameters:
- `DATA_W`, default 8: pixel width in bits.
- `ROWS`, default 9: output image rows.
- `COLS`, default 9: output image columns.

Ports:
- `clk`  input  1  sole clock, rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `load`  input  1  request to snapshot `conv_img` and start streaming.
- `conv_img`  input  ROWS*COLS*DATA_W  flat image. Pixel (i,j) sits at `[(i*COLS+j)*DATA_W +: DATA_W]`.
- `busy`  output  1  high from the accepted `load` until the `done` cycle, inclusive.
- `pix_data`  output  DATA_W  current pixel.
- `pix_valid`  output  1  `pix_data`/`pix_row`/`pix_col`/`pix_last` are valid.
- `pix_ready`  input  1  downstream accepts the pixel this cycle.
- `pix_row`  output  $clog2(ROWS)  row index of the current pixel.
- `pix_col`  output  $clog2(COLS)  column index of the current pixel.
- `pix_last`  output  1  current pixel is (ROWS-1, COLS-1).
- `done`  output  1  one-cycle pulse after the final pixel transfer.

## Operation
State machine: IDLE, STREAM, DONE.

- **IDLE**
  - `load`=1 at an edge: copy `conv_img` into the internal snapshot register, clear row/col counters, go to STREAM.
  - `load`=0: stay in IDLE.
- **STREAM**
  - `pix_valid`=1; `pix_data` = snapshot pixel at (row, col).
  - A transfer occurs at an edge where `pix_valid && pix_ready`.
  - On a transfer: col increments. When col = COLS-1, col wraps to 0 and row increments.
  - The transfer of (ROWS-1, COLS-1) moves the FSM to DONE.
- **DONE**
  - `done`=1 and `pix_valid`=0 for exactly one cycle, then IDLE.

General rules:
- `load` is ignored in STREAM and DONE. The snapshot is never overwritten mid-image.
- `conv_img` may change freely after the load edge; streamed data always comes from the snapshot.
- No arithmetic on pixel values. Data is passed through bit-exact as unsigned DATA_W.
- `pix_last` = `pix_valid` && row==ROWS-1 && col==COLS-1.
- Exactly ROWS*COLS transfers per load (81 by default).

## Timing
- **Reset values:** FSM=IDLE, `busy`=0, `pix_valid`=0, `pix_data`=0, `pix_row`=0, `pix_col`=0, `pix_last`=0, `done`=0, snapshot=0.
- **Start latency:** `load` sampled at edge N gives `pix_valid`=1 with pixel (0,0) after edge N, i.e. one cycle.
- **Handshake:** once `pix_valid` is high it stays high, with data, row, col and last held stable, until a transfer. `pix_valid` never depends combinationally on `pix_ready`.
- **Throughput:** with `pix_ready` held at 1, one pixel per cycle. 81 pixels occupy 81 consecutive cycles, then `done` on cycle 82 after the first valid.
- **Stalls:** `pix_ready`=0 freezes all outputs and counters.
- **Back-to-back images:** `load` asserted during the `done` cycle is ignored. The earliest accepted `load` is the cycle after `done`.
- **Reset mid-stream:** `rst` at any edge forces the reset values at that edge. The partial image is discarded, and no `done` is produced for it.
- **Simultaneous `rst` and `load`:** reset wins, and the FSM stays in IDLE.

## Test plan
- **Basic stream:** reset 5 cycles, drive `conv_img` with pixel k = k+1 (k=0..80), pulse `load`, `pix_ready`=1.
  - Expect `pix_data` 1..81 on 81 consecutive cycles.
  - Row/col sequence (0,0),(0,1)…(0,8),(1,0)…(8,8).
  - `pix_last` only on value 81, `done` pulse one cycle later, `busy` low afterward.
- **Backpressure:** same image with `pix_ready` toggling 1,0,0,1 repeating.
  - Outputs hold during ready=0.
  - Received sequence is still exactly 1..81 with no duplicates or drops.
- **Snapshot isolation:** change `conv_img` to all 8'hFF one cycle after `load`.
  - Expect streamed values still 1..81.
  - A new `load` after `done` then streams 81 × 8'hFF.
- **Load ignored while busy:** pulse `load` at pixel 40 with a different `conv_img`.
  - Expect the stream to continue with 41..81 and no restart.
- **Reset mid-stream:** assert `rst` after pixel 20 transfers.
  - Next cycle expect `pix_valid`=0, `busy`=0, row/col=0, and no `done`.
  - A fresh `load` restarts from pixel (0,0)=1.
- **Full-range data:** pixel k = 255-k.
  - Expect exact 8-bit values 255 down to 175 with no sign/width corruption.
